// File: rtl/lc3b_pkg.sv
// lc3b_pkg: shared LC-3b pipeline definitions.
//   - opcode encodings (IR[15:12])
//   - R7 index (link register for JSR/JSRR/TRAP)
//   - condition-code reset value (Z set)
//   - DE latch struct
package lc3b_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDW  = 4'b0110;
  localparam logic [3:0] OP_STW  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_SHF  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [2:0] R7           = 3'd7;
  localparam logic [2:0] CC_RESET_VAL = 3'b010;

  typedef struct packed {
    logic [15:0] npc;
    logic [15:0] ir;
    logic        v;
  } de_latch_t;

  // Control-flow opcodes hold fetch until AGEX/MEM resolve the target.
  function automatic logic is_ctrl_op(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_JMP) || (op == OP_JSR) || (op == OP_TRAP);
  endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: NUM_REGS x DATA_W architectural register file.
//   clk, reset     : clock, synchronous active-high reset (priority over write)
//   we/waddr/wdata : single write port, updated on rising edge
//   raddr1/rdata1  : combinational read port 1
//   raddr2/rdata2  : combinational read port 2
// Reads return the stored value only; a same-cycle write is not bypassed.
module reg_file #(
  parameter int                NUM_REGS  = 8,
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               AW        = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset)
        regs[r] <= RESET_VAL;
      else if (we && (waddr == AW'(r)))
        regs[r] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: LC-3b decode (DE) stage.
// Owns the DE latch (NPC/IR/V), the 8x16 register file and the N/Z/P CC
// register. Decodes source/destination fields, detects register and CC
// dependencies against AGEX/MEM/SR, and drives next-cycle AGEX latch values.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   fe_npc/fe_ir/fe_v     : fetch outputs, captured when ld_de=1
//   ld_de                 : DE latch load enable
//   mem_stall             : freezes the AGEX latch (ld_agex=0)
//   v_agex_ld_reg, agex_stage_drid : AGEX-resident writer (valid, dest)
//   v_mem_ld_reg,  mem_drid        : MEM-resident writer
//   v_sr_ld_reg, sr_drid, sr_data  : SR writer, also the regfile write port
//   v_agex_ld_cc, v_mem_ld_cc      : downstream CC writers (hazard only)
//   v_sr_ld_cc, sr_nzp             : CC write port
//   dep_stall, v_de_br_stall       : stall flags
//   agex_*                         : next-cycle AGEX latch values
//   ld_agex                        : AGEX latch load enable
// The AGEX-stage destination input is named agex_stage_drid because
// agex_drid is already the outgoing destination id for the AGEX latch.
module decode_stage #(
  parameter logic [15:0] REG_RESET_VAL = 16'h0000,
  parameter logic [2:0]  CC_RESET_VAL  = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] fe_npc,
  input  logic [15:0] fe_ir,
  input  logic        fe_v,
  input  logic        ld_de,
  input  logic        mem_stall,
  input  logic        v_agex_ld_reg,
  input  logic [2:0]  agex_stage_drid,
  input  logic        v_mem_ld_reg,
  input  logic [2:0]  mem_drid,
  input  logic        v_sr_ld_reg,
  input  logic [2:0]  sr_drid,
  input  logic [15:0] sr_data,
  input  logic        v_agex_ld_cc,
  input  logic        v_mem_ld_cc,
  input  logic        v_sr_ld_cc,
  input  logic [2:0]  sr_nzp,
  output logic        dep_stall,
  output logic        v_de_br_stall,
  output logic [15:0] agex_npc,
  output logic [15:0] agex_ir,
  output logic [15:0] agex_sr1,
  output logic [15:0] agex_sr2,
  output logic [2:0]  agex_cc,
  output logic [2:0]  agex_drid,
  output logic        agex_v,
  output logic        ld_agex
);

  import lc3b_pkg::*;

  de_latch_t  de;
  logic [2:0] cc;

  // DE latch
  always_ff @(posedge clk) begin
    if (reset)
      de <= '0;
    else if (ld_de)
      de <= '{npc: fe_npc, ir: fe_ir, v: fe_v};
  end

  // CC register
  always_ff @(posedge clk) begin
    if (reset)
      cc <= CC_RESET_VAL;
    else if (v_sr_ld_cc)
      cc <= sr_nzp;
  end

  // Field decode
  logic [3:0] op;
  logic [2:0] sr1, sr2;
  logic       sr1_needed, sr2_needed;
  logic       is_store, is_alu;

  assign op       = de.ir[15:12];
  assign is_store = (op == OP_STB) || (op == OP_STW);
  assign is_alu   = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
  assign sr1      = de.ir[8:6];
  // Stores read their data register from the DR field.
  assign sr2      = is_store ? de.ir[11:9] : de.ir[2:0];

  always_comb begin
    sr1_needed = 1'b0;
    unique case (op)
      OP_ADD, OP_AND, OP_XOR, OP_SHF,
      OP_LDB, OP_LDW, OP_STB, OP_STW, OP_JMP: sr1_needed = 1'b1;
      OP_JSR:                                 sr1_needed = ~de.ir[11]; // JSRR
      default:                                sr1_needed = 1'b0;
    endcase
  end

  // IR[5]=1 selects the immediate form of ADD/AND/XOR.
  assign sr2_needed = (is_alu && !de.ir[5]) || is_store;

  assign agex_drid = ((op == OP_JSR) || (op == OP_TRAP)) ? R7 : de.ir[11:9];

  // Register file; SR stage owns the write port
  reg_file #(
    .NUM_REGS  (8),
    .DATA_W    (16),
    .RESET_VAL (REG_RESET_VAL)
  ) u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (v_sr_ld_reg),
    .waddr  (sr_drid),
    .wdata  (sr_data),
    .raddr1 (sr1),
    .raddr2 (sr2),
    .rdata1 (agex_sr1),
    .rdata2 (agex_sr2)
  );

  // Dependency detection. The SR term doubles as the missing write-to-read
  // bypass: the reader waits one cycle and then sees the written value.
  logic sr1_hit, sr2_hit, cc_hit;

  assign sr1_hit = (v_agex_ld_reg && (agex_stage_drid == sr1)) ||
                   (v_mem_ld_reg  && (mem_drid        == sr1)) ||
                   (v_sr_ld_reg   && (sr_drid         == sr1));
  assign sr2_hit = (v_agex_ld_reg && (agex_stage_drid == sr2)) ||
                   (v_mem_ld_reg  && (mem_drid        == sr2)) ||
                   (v_sr_ld_reg   && (sr_drid         == sr2));
  assign cc_hit  = (op == OP_BR) && (v_agex_ld_cc || v_mem_ld_cc || v_sr_ld_cc);

  assign dep_stall = de.v && ((sr1_needed && sr1_hit) ||
                              (sr2_needed && sr2_hit) ||
                              cc_hit);

  assign v_de_br_stall = de.v && is_ctrl_op(op);

  // AGEX latch drive; a stalled instruction leaves a bubble behind it
  assign agex_npc = de.npc;
  assign agex_ir  = de.ir;
  assign agex_cc  = cc;
  assign agex_v   = de.v && !dep_stall;
  assign ld_agex  = !mem_stall;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fe_npc, fe_ir;
  logic        fe_v, ld_de, mem_stall;
  logic        v_agex_ld_reg, v_mem_ld_reg, v_sr_ld_reg;
  logic [2:0]  agex_stage_drid, mem_drid, sr_drid;
  logic [15:0] sr_data;
  logic        v_agex_ld_cc, v_mem_ld_cc, v_sr_ld_cc;
  logic [2:0]  sr_nzp;
  logic        dep_stall, v_de_br_stall, agex_v, ld_agex;
  logic [15:0] agex_npc, agex_ir, agex_sr1, agex_sr2;
  logic [2:0]  agex_cc, agex_drid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .fe_npc(fe_npc), .fe_ir(fe_ir), .fe_v(fe_v),
    .ld_de(ld_de), .mem_stall(mem_stall),
    .v_agex_ld_reg(v_agex_ld_reg), .agex_stage_drid(agex_stage_drid),
    .v_mem_ld_reg(v_mem_ld_reg), .mem_drid(mem_drid),
    .v_sr_ld_reg(v_sr_ld_reg), .sr_drid(sr_drid), .sr_data(sr_data),
    .v_agex_ld_cc(v_agex_ld_cc), .v_mem_ld_cc(v_mem_ld_cc),
    .v_sr_ld_cc(v_sr_ld_cc), .sr_nzp(sr_nzp),
    .dep_stall(dep_stall), .v_de_br_stall(v_de_br_stall),
    .agex_npc(agex_npc), .agex_ir(agex_ir), .agex_sr1(agex_sr1),
    .agex_sr2(agex_sr2), .agex_cc(agex_cc), .agex_drid(agex_drid),
    .agex_v(agex_v), .ld_agex(ld_agex)
  );

  // ---------------- reference model ----------------
  logic [15:0] m_rf [8];
  logic [2:0]  m_cc;
  logic [15:0] m_npc, m_ir;
  logic        m_v;

  logic        e_dep, e_br, e_v, e_ld;
  logic [15:0] e_sr1, e_sr2;
  logic [2:0]  e_drid;

  // Set of registers an instruction actually consumes.
  function automatic logic [7:0] reads_of(input logic [15:0] ir);
    logic [7:0] m;
    m = 8'h00;
    case (ir[15:12])
      4'b0001, 4'b0101, 4'b1001: begin
        m[ir[8:6]] = 1'b1;
        if (ir[5] == 1'b0) m[ir[2:0]] = 1'b1;
      end
      4'b1101, 4'b0010, 4'b0110, 4'b1100: m[ir[8:6]] = 1'b1;
      4'b0011, 4'b0111: begin m[ir[8:6]] = 1'b1; m[ir[11:9]] = 1'b1; end
      4'b0100: if (ir[11] == 1'b0) m[ir[8:6]] = 1'b1;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  task automatic model_eval;
    logic [7:0] busy;
    logic [3:0] op;
    logic       cc_busy;
    op   = m_ir[15:12];
    busy = 8'h00;
    if (v_agex_ld_reg) busy[agex_stage_drid] = 1'b1;
    if (v_mem_ld_reg)  busy[mem_drid]        = 1'b1;
    if (v_sr_ld_reg)   busy[sr_drid]         = 1'b1;
    cc_busy = (op == 4'b0000) && (v_agex_ld_cc || v_mem_ld_cc || v_sr_ld_cc);
    e_dep  = m_v && (((reads_of(m_ir) & busy) != 8'h00) || cc_busy);
    e_br   = m_v && (op inside {4'b0000, 4'b1100, 4'b0100, 4'b1111});
    e_v    = m_v && !e_dep;
    e_ld   = !mem_stall;
    e_sr1  = m_rf[m_ir[8:6]];
    e_sr2  = (op == 4'b0011 || op == 4'b0111) ? m_rf[m_ir[11:9]] : m_rf[m_ir[2:0]];
    e_drid = (op == 4'b0100 || op == 4'b1111) ? 3'd7 : m_ir[11:9];
  endtask

  // Advance one clock: update the model from the inputs seen at the edge.
  task automatic tick;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
      m_cc = 3'b010; m_v = 1'b0; m_npc = 16'h0; m_ir = 16'h0;
    end else begin
      if (ld_de) begin m_npc = fe_npc; m_ir = fe_ir; m_v = fe_v; end
      if (v_sr_ld_reg) m_rf[sr_drid] = sr_data;
      if (v_sr_ld_cc)  m_cc = sr_nzp;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    reset = 1'b0; ld_de = 1'b0; fe_v = 1'b0; mem_stall = 1'b0;
    v_agex_ld_reg = 1'b0; v_mem_ld_reg = 1'b0; v_sr_ld_reg = 1'b0;
    v_agex_ld_cc = 1'b0; v_mem_ld_cc = 1'b0; v_sr_ld_cc = 1'b0;
    agex_stage_drid = 3'd0; mem_drid = 3'd0; sr_drid = 3'd0;
    sr_data = 16'h0; sr_nzp = 3'b000;
  endtask

  task automatic load_de(input logic [15:0] ir, input logic [15:0] npc);
    ld_de = 1'b1; fe_v = 1'b1; fe_ir = ir; fe_npc = npc;
    tick();
    ld_de = 1'b0; fe_ir = $urandom; fe_npc = $urandom;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    quiet();
    reset = 1'b1; ld_de = 1'b1; fe_v = 1'b1; fe_ir = 16'h12C4; fe_npc = 16'h4444;
    v_sr_ld_reg = 1'b1; sr_drid = 3'd2; sr_data = 16'hFFFF;
    v_sr_ld_cc = 1'b1; sr_nzp = 3'b100;
    tick();
    quiet();
    #1;
    total++; if (agex_v !== 1'b0) begin bad++; $display("FAIL reset_agex_v got=%b want=0", agex_v); end
    total++; if (dep_stall !== 1'b0) begin bad++; $display("FAIL reset_dep got=%b want=0", dep_stall); end
    total++; if (v_de_br_stall !== 1'b0) begin bad++; $display("FAIL reset_br got=%b want=0", v_de_br_stall); end
    total++; if (agex_npc !== 16'h0 || agex_ir !== 16'h0) begin bad++; $display("FAIL reset_de got npc=%h ir=%h want 0", agex_npc, agex_ir); end
    total++; if (agex_cc !== 3'b010) begin bad++; $display("FAIL reset_cc got=%b want=010", agex_cc); end
    total++; if (ld_agex !== 1'b1) begin bad++; $display("FAIL reset_ld_agex got=%b want=1", ld_agex); end
    // Sweep every register through both read ports via ADD Rx,Ri,Ri.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] r;
      r = 3'(i);
      load_de({4'b0001, 3'd0, r, 3'b000, r}, 16'h0);
      total++; if (agex_sr1 !== 16'h0 || agex_sr2 !== 16'h0) begin
        bad++; $display("FAIL reset_reg R%0d got sr1=%h sr2=%h want 0", i, agex_sr1, agex_sr2);
      end
    end
  endtask

  task automatic test_reg_write_read;
    quiet();
    v_sr_ld_reg = 1'b1; sr_drid = 3'd3; sr_data = 16'h1234;
    tick();
    quiet();
    load_de(16'h12C4, 16'h3002);
    total++; if (agex_sr1 !== 16'h1234) begin bad++; $display("FAIL wr_rd_sr1 got=%h want=1234", agex_sr1); end
    total++; if (agex_drid !== 3'd1) begin bad++; $display("FAIL wr_rd_drid got=%0d want=1", agex_drid); end
    total++; if (agex_v !== 1'b1 || dep_stall !== 1'b0) begin bad++; $display("FAIL wr_rd_valid got v=%b dep=%b want 1/0", agex_v, dep_stall); end
    total++; if (agex_npc !== 16'h3002) begin bad++; $display("FAIL wr_rd_npc got=%h want=3002", agex_npc); end
  endtask

  task automatic test_data_hazard;
    // DE still holds ADD R1,R3,R4
    v_mem_ld_reg = 1'b1; mem_drid = 3'd4;
    #1;
    total++; if (dep_stall !== 1'b1 || agex_v !== 1'b0) begin bad++; $display("FAIL hazard_sr2 got dep=%b v=%b want 1/0", dep_stall, agex_v); end
    tick();
    v_mem_ld_reg = 1'b0;
    #1;
    total++; if (agex_v !== 1'b1 || agex_ir !== 16'h12C4) begin bad++; $display("FAIL hazard_clear got v=%b ir=%h want 1/12c4", agex_v, agex_ir); end
  endtask

  task automatic test_immediate;
    quiet();
    load_de(16'h12E4, 16'h3004);
    v_agex_ld_reg = 1'b1; agex_stage_drid = 3'd4;
    #1;
    total++; if (dep_stall !== 1'b0 || agex_v !== 1'b1) begin bad++; $display("FAIL imm_no_dep got dep=%b v=%b want 0/1", dep_stall, agex_v); end
    agex_stage_drid = 3'd3;
    #1;
    total++; if (dep_stall !== 1'b1) begin bad++; $display("FAIL imm_sr1_dep got=%b want=1", dep_stall); end
    quiet();
  endtask

  task automatic test_branch;
    quiet();
    v_sr_ld_cc = 1'b1; sr_nzp = 3'b100;
    tick();
    quiet();
    load_de(16'h0402, 16'h3006);
    v_agex_ld_cc = 1'b1;
    #1;
    total++; if (dep_stall !== 1'b1 || v_de_br_stall !== 1'b1) begin bad++; $display("FAIL br_cc_dep got dep=%b br=%b want 1/1", dep_stall, v_de_br_stall); end
    v_agex_ld_cc = 1'b0;
    #1;
    total++; if (dep_stall !== 1'b0 || v_de_br_stall !== 1'b1) begin bad++; $display("FAIL br_clear got dep=%b br=%b want 0/1", dep_stall, v_de_br_stall); end
    total++; if (agex_cc !== 3'b100) begin bad++; $display("FAIL br_cc got=%b want=100", agex_cc); end
  endtask

  task automatic test_stall_hold;
    for (int i = 0; i < 3; i++) begin
      ld_de = 1'b0; fe_v = 1'b1; fe_ir = $urandom; fe_npc = $urandom;
      tick();
      total++; if (agex_ir !== 16'h0402 || v_de_br_stall !== 1'b1) begin bad++; $display("FAIL hold_ir cycle %0d got ir=%h br=%b want 0402/1", i, agex_ir, v_de_br_stall); end
    end
    mem_stall = 1'b1;
    #1;
    total++; if (ld_agex !== 1'b0) begin bad++; $display("FAIL mem_stall_ld got=%b want=0", ld_agex); end
    mem_stall = 1'b0;
  endtask

  task automatic test_sr_same_cycle;
    quiet();
    load_de(16'h12C4, 16'h3008);
    v_sr_ld_reg = 1'b1; sr_drid = 3'd3; sr_data = 16'hBEEF;
    #1;
    total++; if (dep_stall !== 1'b1 || agex_v !== 1'b0) begin bad++; $display("FAIL sr_same_dep got dep=%b v=%b want 1/0", dep_stall, agex_v); end
    tick();
    quiet();
    #1;
    total++; if (agex_sr1 !== 16'hBEEF || dep_stall !== 1'b0) begin bad++; $display("FAIL sr_same_read got sr1=%h dep=%b want beef/0", agex_sr1, dep_stall); end
  endtask

  task automatic test_reset_mid_stall;
    quiet();
    v_mem_ld_reg = 1'b1; mem_drid = 3'd3;   // DE holds ADD on R3, stalled
    reset = 1'b1; v_sr_ld_reg = 1'b1; sr_drid = 3'd3; sr_data = 16'h5555;
    tick();
    quiet();
    #1;
    total++; if (agex_v !== 1'b0 || v_de_br_stall !== 1'b0 || agex_ir !== 16'h0) begin bad++; $display("FAIL rst_mid got v=%b br=%b ir=%h want 0/0/0", agex_v, v_de_br_stall, agex_ir); end
    load_de(16'h12C4, 16'h0);
    total++; if (agex_sr1 !== 16'h0000) begin bad++; $display("FAIL rst_sr_write got=%h want=0000", agex_sr1); end
  endtask

  task automatic test_random;
    quiet();
    for (int n = 0; n < 600; n++) begin
      reset           = ($urandom_range(0, 59) == 0);
      ld_de           = $urandom_range(0, 1);
      fe_v            = ($urandom_range(0, 3) != 0);
      fe_ir           = $urandom;
      fe_npc          = $urandom;
      mem_stall       = ($urandom_range(0, 4) == 0);
      v_agex_ld_reg   = ($urandom_range(0, 3) == 0);
      v_mem_ld_reg    = ($urandom_range(0, 3) == 0);
      v_sr_ld_reg     = ($urandom_range(0, 2) == 0);
      agex_stage_drid = $urandom;
      mem_drid        = $urandom;
      sr_drid         = $urandom;
      sr_data         = $urandom;
      v_agex_ld_cc    = ($urandom_range(0, 5) == 0);
      v_mem_ld_cc     = ($urandom_range(0, 5) == 0);
      v_sr_ld_cc      = ($urandom_range(0, 3) == 0);
      sr_nzp          = $urandom;
      #1;
      model_eval();
      total++;
      if (dep_stall !== e_dep || v_de_br_stall !== e_br || agex_v !== e_v || ld_agex !== e_ld) begin
        bad++; $display("FAIL rand_flags n=%0d ir=%h got dep=%b br=%b v=%b ld=%b want %b %b %b %b",
                        n, m_ir, dep_stall, v_de_br_stall, agex_v, ld_agex, e_dep, e_br, e_v, e_ld);
      end
      total++;
      if (agex_sr1 !== e_sr1 || agex_sr2 !== e_sr2 || agex_drid !== e_drid || agex_cc !== m_cc ||
          agex_ir !== m_ir || agex_npc !== m_npc) begin
        bad++; $display("FAIL rand_data n=%0d got sr1=%h sr2=%h dr=%0d cc=%b ir=%h npc=%h want %h %h %0d %b %h %h",
                        n, agex_sr1, agex_sr2, agex_drid, agex_cc, agex_ir, agex_npc,
                        e_sr1, e_sr2, e_drid, m_cc, m_ir, m_npc);
      end
      tick();
    end
    quiet();
  endtask

  initial begin
    quiet();
    fe_ir = 16'h0; fe_npc = 16'h0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_cc = 3'b010; m_v = 1'b0; m_ir = 16'h0; m_npc = 16'h0;
    #2;
    test_reset();
    test_reg_write_read();
    test_data_hazard();
    test_immediate();
    test_branch();
    test_stall_hold();
    test_sr_same_cycle();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of fetch in the LC-3b pipeline.
- Owns the DE pipeline latch (NPC, IR, V), the 8x16 architectural register file and the N/Z/P condition-code register.
- Extracts and reads source registers, detects data and CC dependencies, and raises the branch-stall flag that freezes fetch.
- Drives the next-cycle values of the AGEX latch along with its load enable.

Parameters:
REG_RESET_VAL, 16'h0000, value loaded into R0-R7 on reset
CC_RESET_VAL, 3'b010, N/Z/P value after reset (Z set)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
fe_npc  in  16  PC+2 from fetch
fe_ir  in  16  instruction from fetch (zero when memory not ready)
fe_v  in  1  fetch valid
ld_de  in  1  DE latch load enable from fetch
mem_stall  in  1  memory stage stall
v_agex_ld_reg  in  1  AGEX instr valid and writes a register
agex_drid  in  3  AGEX destination
v_mem_ld_reg  in  1  MEM instr valid and writes a register
mem_drid  in  3  MEM destination
v_sr_ld_reg  in  1  SR stage register write strobe
sr_drid  in  3  SR destination
sr_data  in  16  SR write data
v_agex_ld_cc  in  1  AGEX instr sets CC
v_mem_ld_cc  in  1  MEM instr sets CC
v_sr_ld_cc  in  1  SR stage CC write strobe
sr_nzp  in  3  CC value written by SR
dep_stall  out  1  operand/CC dependency stall
v_de_br_stall  out  1  valid control-flow instruction in DE
agex_npc  out  16  DE.NPC passthrough
agex_ir  out  16  DE.IR passthrough
agex_sr1  out  16  R[sr1] read data
agex_sr2  out  16  R[sr2] read data
agex_cc  out  3  current N/Z/P
agex_drid  out  3  destination register id
agex_v  out  1  valid into AGEX
ld_agex  out  1  AGEX latch load enable

Behaviour:
- Reset: DE.V=0, DE.NPC=0, DE.IR=0, R0-R7=REG_RESET_VAL, CC=CC_RESET_VAL.
- Reset has priority over every load or write in the same cycle. A reset mid-stall discards the DE contents.
- Reset-state outputs (from DE.V=0): dep_stall=0, v_de_br_stall=0, agex_v=0, agex_npc=0, agex_ir=0, ld_agex=!mem_stall.
- DE latch: when ld_de=1, NPC<=fe_npc, IR<=fe_ir, V<=fe_v. When ld_de=0, hold.
- Field decode from DE.IR (opcode = IR[15:12]):
  - sr1 = IR[8:6].
  - sr2 = IR[11:9] for STB/STW (0011/0111); otherwise IR[2:0].
  - sr1 is needed for ADD, AND, XOR, SHF, LDB, LDW, STB, STW, JMP, and JSRR (0100 with IR[11]=0).
  - sr2 is needed for ADD/AND/XOR when IR[5]=0, and for STB/STW.
  - drid = 3'd7 for JSR/JSRR and TRAP; IR[11:9] otherwise.
- Register file: written at the clock edge when v_sr_ld_reg=1, R[sr_drid]<=sr_data. Reads are combinational.
  - No write-to-read bypass. The SR-stage hazard term below covers same-cycle write/read.
- CC register: loads sr_nzp at the clock edge when v_sr_ld_cc=1.
- dep_stall = DE.V AND (any of):
  - sr1 needed and a valid (agex/mem/sr) ld_reg with drid == sr1
  - sr2 needed and the same match against sr2
  - opcode BR (0000) and any of v_agex_ld_cc, v_mem_ld_cc, v_sr_ld_cc
- v_de_br_stall = DE.V AND opcode in {BR 0000, JMP 1100, JSR 0100, TRAP 1111}. It stays asserted while DE holds the instruction.
- ld_agex = !mem_stall.
- agex_v = DE.V AND !dep_stall. A stalled DE instruction inserts a bubble into AGEX.
- Latency: an instruction loaded into DE at edge N presents AGEX values during cycle N+1. With no stall it enters AGEX at edge N+1.
- Simultaneous events:
  - An SR write to a register being read in the same cycle produces dep_stall=1. The next cycle reads the new value.
  - A reset coinciding with v_sr_ld_reg leaves the register at REG_RESET_VAL.
- All outputs other than the state registers are combinational from DE state and inputs. No combinational path from fe_* to outputs.

Decomposition:
- Shared package lc3b_pkg holds:
  - opcode localparams (OP_BR, OP_ADD, OP_LDB, OP_STB, OP_JSR, OP_AND, OP_LDW, OP_STW, OP_RTI, OP_XOR, OP_JMP, OP_SHF, OP_LEA, OP_TRAP)
  - R7 index constant
  - CC_RESET_VAL
- One sub-module: reg_file (8x16, one write port, two combinational read ports, synchronous reset).

Test Plan:
- Reset: pulse reset with ld_de=1 and fe_v=1 -> DE.V=0, agex_v=0, all registers 0, agex_cc=3'b010.
- Register write then read:
  - Write R3=16'h1234 via SR.
  - Next cycle load ADD R1,R3,R4 (IR=16'h12C4), no hazards.
  - Result: agex_sr1=16'h1234, agex_drid=1, agex_v=1, dep_stall=0.
- Data hazard: DE holds ADD R1,R3,R4 with v_mem_ld_reg=1, mem_drid=4 -> dep_stall=1, agex_v=0. Drop the hazard -> agex_v=1 next cycle.
- Immediate operand: ADD R1,R3,#4 (IR=16'h12E4) with agex_drid=4 valid -> dep_stall=0.
- Branch:
  - DE holds BRz (16'h0402) with v_agex_ld_cc=1 -> dep_stall=1, v_de_br_stall=1.
  - Clear CC hazards -> dep_stall=0, v_de_br_stall=1, agex_cc equals the last sr_nzp.
- Stall hold: ld_de=0 for 3 cycles with changing fe_ir -> agex_ir unchanged. Assert mem_stall=1 -> ld_agex=0.
